// File: rtl/dmem_responder_pkg.sv
// Shared widths, enums and the legality check for the CPU data-memory responder slice.
package cpu_mem_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    typedef enum logic {
        SZ_BYTE  = 1'b0,
        SZ_DWORD = 1'b1
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Compares the full 64-bit address so high garbage bits can never alias into the array.
    function automatic logic access_illegal(input logic [ADDR_W-1:0] addr,
                                            input size_e             size,
                                            input logic [ADDR_W-1:0] depth);
        return (addr >= depth) || ((size == SZ_DWORD) && (addr[2:0] != 3'b000));
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the CPU memory stage (master) and the responder (slave).
interface dmem_responder_if;
    import cpu_mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    size_e             req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_responder_array.sv
// Byte-wide little-endian storage with one synchronous port; contents are deliberately not reset.
module dmem_array
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic                           we,
    input  size_e                          size,
    input  logic [$clog2(DEPTH_BYTES)-1:0] idx,
    input  logic [DATA_W-1:0]              wdata,
    output logic [DATA_W-1:0]              rdata
);

    localparam int IDX_W = $clog2(DEPTH_BYTES);

    logic [7:0] mem [DEPTH_BYTES];

    // Doubleword accesses are always 8-byte aligned, so the low index bits select the byte lane.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                if (size == SZ_DWORD) begin
                    for (int i = 0; i < 8; i++) begin
                        mem[{idx[IDX_W-1:3], 3'(i)}] <= wdata[8*i +: 8];
                    end
                end else begin
                    mem[idx] <= wdata[7:0];
                end
            end else begin
                if (size == SZ_DWORD) begin
                    for (int i = 0; i < 8; i++) begin
                        rdata[8*i +: 8] <= mem[{idx[IDX_W-1:3], 3'(i)}];
                    end
                end else begin
                    rdata <= {{(DATA_W-8){1'b0}}, mem[idx]};
                end
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed access latency, commit on the edge entering RESP.
module dmem_responder
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 3
) (
    input  logic           clk,
    input  logic           reset,
    dmem_responder_if.slave bus
);

    localparam int                IDX_W   = $clog2(DEPTH_BYTES);
    localparam int                CNT_W   = (LATENCY < 2) ? 1 : $clog2(LATENCY);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH_BYTES);
    localparam bit                DIRECT  = (LATENCY == 1);

    state_e            state;
    state_e            next_state;
    logic [CNT_W-1:0]  cnt;
    logic              write_q;
    size_e             size_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;

    logic              accept;
    logic              commit;
    logic              req_illegal;
    logic              c_write;
    size_e             c_size;
    logic [IDX_W-1:0]  c_idx;
    logic [DATA_W-1:0] c_wdata;
    logic              c_err;
    logic              array_en;
    logic [DATA_W-1:0] array_rdata;

    assign req_illegal = access_illegal(bus.req_addr, bus.req_size, DEPTH_A);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Legality is decided at accept time, so only the in-range index bits need to be kept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            write_q <= 1'b0;
            size_q  <= SZ_BYTE;
            idx_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            cnt     <= CNT_W'(LATENCY - 1);
            write_q <= bus.req_write;
            size_q  <= bus.req_size;
            idx_q   <= bus.req_addr[IDX_W-1:0];
            wdata_q <= bus.req_wdata;
            err_q   <= req_illegal;
        end else if (state == S_WAIT) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (DIRECT) begin
                        commit     = 1'b1;
                        next_state = S_RESP;
                    end else begin
                        next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    commit     = 1'b1;
                    next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // With single-cycle latency the commit happens on the accept edge, straight from the bus.
    assign c_write  = DIRECT ? bus.req_write              : write_q;
    assign c_size   = DIRECT ? bus.req_size               : size_q;
    assign c_idx    = DIRECT ? bus.req_addr[IDX_W-1:0]    : idx_q;
    assign c_wdata  = DIRECT ? bus.req_wdata              : wdata_q;
    assign c_err    = DIRECT ? req_illegal                : err_q;
    assign array_en = commit && !c_err && reset;

    dmem_array #(
        .DEPTH_BYTES(DEPTH_BYTES)
    ) u_array (
        .clk  (clk),
        .en   (array_en),
        .we   (c_write),
        .size (c_size),
        .idx  (c_idx),
        .wdata(c_wdata),
        .rdata(array_rdata)
    );

    assign bus.req_ready  = reset && (state == S_IDLE);
    assign bus.resp_valid = (state == S_RESP);
    assign bus.resp_err   = (state == S_RESP) && err_q;
    assign bus.resp_rdata = ((state == S_RESP) && !err_q && !write_q) ? array_rdata : '0;

endmodule
